// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared instruction-memory geometry and loader state encoding
package imem_pkg;

    localparam int IMEM_DEPTH     = 64;
    localparam int IMEM_BASE_WORD = 25;
    localparam int IMEM_AW        = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - big-endian byte-to-word assembler with byte index and word-complete strobe
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [23:0] r_shift;
    logic [1:0]  r_byte_idx;

    // The completing byte is merged combinationally so the top can register the write on the same edge.
    assign o_word      = {r_shift, i_byte};
    assign o_word_done = i_accept && (r_byte_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= 24'd0;
            r_byte_idx <= 2'd0;
        end else if (i_clear) begin
            r_shift    <= 24'd0;
            r_byte_idx <= 2'd0;
        end else if (i_accept) begin
            r_shift    <= {r_shift[15:0], i_byte};
            r_byte_idx <= r_byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction memory loader top; optional running XOR checksum under IMEM_LOADER_CHECKSUM_EN
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH     = IMEM_DEPTH,
    parameter int BASE_WORD = IMEM_BASE_WORD,
    parameter int AW        = IMEM_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    loadByte,
    input  logic          loadValid,
    input  logic          loadLast,
    output logic          loadReady,
    output logic          memWe,
    output logic [AW-1:0] memAddr,
    output logic [31:0]   memData,
    output logic          cpuHold,
    output logic          done,
    output logic          loadErr,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [31:0]   checksum,
`endif
    output logic [AW:0]   wordCount
);

    localparam logic [AW-1:0] LP_BASE_ADDR = AW'(BASE_WORD);
    localparam logic [AW-1:0] LP_LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LP_ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   LP_CNT_ONE   = {{AW{1'b0}}, 1'b1};

    loader_state_t r_state;
    logic          r_load_ready;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_data;
    logic          r_cpu_hold;
    logic          r_done;
    logic          r_err;
    logic [AW:0]   r_word_count;
    logic [AW-1:0] r_next_addr;
    logic          r_full;

    logic          w_accept;
    logic          w_start_ok;
    logic          w_write;
    logic [31:0]   w_word;
    logic          w_word_done;

    // Ready is only ever high in LOAD, so it doubles as the state qualifier for a handshake.
    assign w_accept   = loadValid && r_load_ready;
    assign w_start_ok = start && (r_state != LOAD);
    assign w_write    = w_word_done && !r_full;

    byte_packer u_byte_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_start_ok),
        .i_accept    (w_accept),
        .i_byte      (loadByte),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_load_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= LP_BASE_ADDR;
            r_mem_data   <= 32'd0;
            r_cpu_hold   <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= '0;
            r_next_addr  <= LP_BASE_ADDR;
            r_full       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        r_state      <= LOAD;
                        r_load_ready <= 1'b1;
                        r_cpu_hold   <= 1'b1;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_word_count <= '0;
                        r_next_addr  <= LP_BASE_ADDR;
                        r_mem_addr   <= LP_BASE_ADDR;
                        r_full       <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        if (r_full) begin
                            // Top word already written: any further byte is an overflow.
                            r_state      <= ERR;
                            r_load_ready <= 1'b0;
                            r_err        <= 1'b1;
                        end else if (w_word_done) begin
                            r_mem_we     <= 1'b1;
                            r_mem_data   <= w_word;
                            r_mem_addr   <= r_next_addr;
                            r_word_count <= r_word_count + LP_CNT_ONE;
                            if (r_next_addr == LP_LAST_ADDR) begin
                                r_full <= 1'b1;
                            end else begin
                                r_next_addr <= r_next_addr + LP_ADDR_ONE;
                            end
                            if (loadLast) begin
                                r_state      <= DONE;
                                r_load_ready <= 1'b0;
                                r_done       <= 1'b1;
                                r_cpu_hold   <= 1'b0;
                            end
                        end else if (loadLast) begin
                            r_state      <= ERR;
                            r_load_ready <= 1'b0;
                            r_err        <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_load_ready <= 1'b0;
                    r_cpu_hold   <= 1'b1;
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= 32'd0;
        end else if (w_start_ok) begin
            r_checksum <= 32'd0;
        end else if (w_write) begin
            r_checksum <= r_checksum ^ w_word;
        end
    end

    assign checksum = r_checksum;
`endif

    assign loadReady = r_load_ready;
    assign memWe     = r_mem_we;
    assign memAddr   = r_mem_addr;
    assign memData   = r_mem_data;
    assign cpuHold   = r_cpu_hold;
    assign done      = r_done;
    assign loadErr   = r_err;
    assign wordCount = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a word-level model
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  loadByte;
    logic        loadValid;
    logic        loadLast;
    logic        loadReady;
    logic        memWe;
    logic [5:0]  memAddr;
    logic [31:0] memData;
    logic        cpuHold;
    logic        done;
    logic        loadErr;
    logic [6:0]  wordCount;

    int n_vec = 0;
    int n_err = 0;

    logic [5:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] tb_mem [0:63];

    imem_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .loadByte  (loadByte),
        .loadValid (loadValid),
        .loadLast  (loadLast),
        .loadReady (loadReady),
        .memWe     (memWe),
        .memAddr   (memAddr),
        .memData   (memData),
        .cpuHold   (cpuHold),
        .done      (done),
        .loadErr   (loadErr),
        .wordCount (wordCount)
    );

    always #5 clk = ~clk;

    // Bench-side instruction memory fed only by observed write strobes.
    always @(negedge clk) begin
        if (rst_n && memWe) begin
            wr_addr_q.push_back(memAddr);
            wr_data_q.push_back(memData);
            tb_mem[memAddr] = memData;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_hold"}, cpuHold, 1);
        check({tag, "_we"}, memWe, 0);
        check({tag, "_addr"}, memAddr, 25);
        check({tag, "_ready"}, loadReady, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, loadErr, 0);
        check({tag, "_count"}, wordCount, 0);
        check({tag, "_data"}, memData, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic drive_stream(input logic [7:0] b[$], input bit use_last, input int gap_pct,
                                input int mid_start);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        while (i < b.size() && cyc < 5000) begin
            loadValid = ($urandom_range(99) >= gap_pct);
            loadByte  = loadValid ? b[i] : 8'($urandom);
            loadLast  = loadValid && use_last && (i == b.size() - 1);
            start     = (i == mid_start);
            @(negedge clk);
            if (loadValid && loadReady) i++;
            @(posedge clk);
            #1;
            cyc++;
        end
        loadValid = 1'b0;
        loadLast  = 1'b0;
        start     = 1'b0;
        if (i < b.size()) check("stream_timeout", i, b.size());
    endtask

    function automatic logic [31:0] model_word(input logic [7:0] b[$], input int k);
        return (32'(b[4*k]) << 24) + (32'(b[4*k+1]) << 16) + (32'(b[4*k+2]) << 8) + 32'(b[4*k+3]);
    endfunction

    task automatic run_load(input logic [7:0] b[$], input bit use_last, input int gap_pct,
                            input int mid_start, input string tag);
        int  nfull;
        int  nexp;
        bit  exp_done;
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        drive_stream(b, use_last, gap_pct, mid_start);
        nfull    = b.size() / 4;
        exp_done = use_last && (b.size() % 4 == 0) && (nfull <= 39);
        nexp     = (nfull > 39) ? 39 : nfull;
        @(negedge clk);
        check({tag, "_final_we"}, memWe, exp_done);
        check({tag, "_done"}, done, exp_done);
        check({tag, "_hold"}, cpuHold, !exp_done);
        check({tag, "_err"}, loadErr, !exp_done);
        check({tag, "_ready"}, loadReady, 0);
        repeat (2) @(negedge clk);
        check({tag, "_nwrites"}, wr_addr_q.size(), nexp);
        for (int k = 0; k < nexp && k < wr_addr_q.size(); k++) begin
            check({tag, "_addr"}, wr_addr_q[k], 25 + k);
            check({tag, "_data"}, wr_data_q[k], model_word(b, k));
        end
        check({tag, "_count"}, wordCount, nexp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] prog[$];
        logic [7:0] rb[$];
        int         n;
        int         nw;

        rst_n = 1'b0;
        start = 1'b0;
        loadValid = 1'b0;
        loadLast = 1'b0;
        loadByte = 8'h00;
        for (int a = 0; a < 64; a++) tb_mem[a] = 32'h0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        prog = {8'h8C, 8'h22, 8'h00, 8'h00, 8'h8C, 8'h23, 8'h01, 8'h00,
                8'h8C, 8'h24, 8'h02, 8'h00, 8'h8C, 8'h25, 8'h03, 8'h00};
        run_load(prog, 1'b1, 0, -1, "dir");

        // Bytes offered while DONE must be ignored.
        for (int c = 0; c < 6; c++) begin
            loadValid = 1'b1;
            loadLast  = 1'b1;
            loadByte  = 8'($urandom);
            @(negedge clk);
            check("idle_ready", loadReady, 0);
            check("idle_we", memWe, 0);
            @(posedge clk);
            #1;
        end
        loadValid = 1'b0;
        loadLast  = 1'b0;
        @(negedge clk);
        check("idle_nwrites", wr_addr_q.size(), 4);
        check("idle_count", wordCount, 4);
        check("idle_done", done, 1);
        @(posedge clk);
        #1;

        run_load(prog, 1'b1, 40, -1, "gaps");

        for (int t = 0; t < 6; t++) begin
            rb.delete();
            nw = $urandom_range(1, 12);
            for (int j = 0; j < 4 * nw; j++) rb.push_back(8'($urandom));
            run_load(rb, 1'b1, 30, int'($urandom_range(0, 4 * nw - 2)), "rand");
        end

        rb.delete();
        nw = $urandom_range(0, 3);
        for (int j = 0; j < 4 * nw + 2; j++) rb.push_back(8'($urandom));
        run_load(rb, 1'b1, 20, -1, "trunc");
        pulse_start();
        @(negedge clk);
        check("restart_err", loadErr, 0);
        check("restart_count", wordCount, 0);
        check("restart_addr", memAddr, 25);
        check("restart_ready", loadReady, 1);
        @(posedge clk);
        #1;

        rb.delete();
        for (int j = 0; j < 157; j++) rb.push_back(8'($urandom));
        run_load(rb, 1'b0, 10, -1, "ovf");
        n = 0;
        foreach (wr_addr_q[k]) if (wr_addr_q[k] == 6'd0) n++;
        check("ovf_addr0", n, 0);
        if (wr_addr_q.size() > 0) check("ovf_lastaddr", wr_addr_q[wr_addr_q.size() - 1], 63);

        rb.delete();
        for (int j = 0; j < 156; j++) rb.push_back(8'($urandom));
        run_load(rb, 1'b1, 10, -1, "full");

        rb.delete();
        for (int j = 0; j < 6; j++) rb.push_back(8'($urandom));
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        drive_stream(rb, 1'b0, 0, -1);
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_mid_we", memWe, 0);
        end
        check("rst_mid_nwrites", wr_addr_q.size(), 1);
        check("rst_mid_mem25", tb_mem[25], model_word(rb, 0));
        check_reset("rst_mid");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_we", wr_addr_q.size(), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
